// File: rtl/cache_types_pkg.sv
// Shared types and default geometry for the L2 line-to-burst memory adapter.
package cache_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_e;

  localparam int unsigned S_OFFSET  = 5;
  localparam int unsigned S_LINE    = 256;
  localparam int unsigned S_BEAT    = 64;
  localparam int unsigned NUM_BEATS = S_LINE / S_BEAT;

  // Beat counter width; a single-beat burst still needs a 1-bit counter.
  function automatic int unsigned beat_cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/line_burst_adapter_if.sv
// Cache-line request port plus physical-memory burst port of the adapter.
// slave is the adapter's view; master is the cache/memory environment's view.
interface line_burst_adapter_if #(
  parameter int unsigned S_LINE = cache_types_pkg::S_LINE,
  parameter int unsigned S_BEAT = cache_types_pkg::S_BEAT
);

  logic              upstream_read;
  logic              upstream_write;
  logic [31:0]       upstream_address;
  logic [S_LINE-1:0] upstream_wdata;
  logic [S_LINE-1:0] upstream_rdata;
  logic              upstream_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [S_BEAT-1:0] pmem_wdata;
  logic [S_BEAT-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  upstream_read, upstream_write, upstream_address, upstream_wdata,
    output upstream_rdata, upstream_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output upstream_read, upstream_write, upstream_address, upstream_wdata,
    input  upstream_rdata, upstream_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/line_beat_shifter.sv
// Line storage for the adapter: latched writeback line with beat select,
// assembled read line with beat load, and the shared beat counter.
module line_beat_shifter
  import cache_types_pkg::*;
#(
  parameter int unsigned S_LINE = cache_types_pkg::S_LINE,
  parameter int unsigned S_BEAT = cache_types_pkg::S_BEAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic              load_wline_i,
  input  logic              store_beat_i,
  input  logic [S_LINE-1:0] wline_i,
  input  logic [S_BEAT-1:0] beat_i,
  output logic              last_beat_o,
  output logic [S_BEAT-1:0] wbeat_o,
  output logic [S_LINE-1:0] rline_o
);

  localparam int unsigned BEATS = S_LINE / S_BEAT;
  localparam int unsigned CNT_W = beat_cnt_width(BEATS);

  logic [CNT_W-1:0]             beat_q;
  logic [BEATS-1:0][S_BEAT-1:0] wline_q;
  logic [BEATS-1:0][S_BEAT-1:0] rline_q;

  assign last_beat_o = (beat_q == CNT_W'(BEATS - 1));
  assign wbeat_o     = wline_q[beat_q];
  assign rline_o     = rline_q;

  // Counter saturates on the last beat; only clear_i returns it to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      if (clear_i) begin
        beat_q <= '0;
      end else if (advance_i && !last_beat_o) begin
        beat_q <= beat_q + CNT_W'(1);
      end
      if (load_wline_i) begin
        wline_q <= wline_i;
      end
      if (store_beat_i) begin
        rline_q[beat_q] <= beat_i;
      end
    end
  end

endmodule

// File: rtl/line_burst_adapter.sv
// Turns one cache line read/writeback into an ascending burst of memory beats
// and returns a single-cycle line response. Optional perf counters: LINE_BURST_PERF_EN.
module line_burst_adapter
  import cache_types_pkg::*;
#(
  parameter int unsigned S_OFFSET = cache_types_pkg::S_OFFSET,
  parameter int unsigned S_LINE   = cache_types_pkg::S_LINE,
  parameter int unsigned S_BEAT   = cache_types_pkg::S_BEAT
) (
  input  logic                 clk,
  input  logic                 rst,
  line_burst_adapter_if.slave  bus
`ifdef LINE_BURST_PERF_EN
  ,
  output logic [31:0]          perf_reads,
  output logic [31:0]          perf_writes,
  output logic [31:0]          perf_stall_cycles
`endif
);

  localparam logic [31:0] ADDR_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

  adapter_state_e state_q;
  logic           rd_q;
  logic           wr_q;
  logic           resp_q;
  logic           is_write_q;
  logic [31:0]    addr_q;

  logic              last_beat;
  logic [S_BEAT-1:0] wbeat;
  logic [S_LINE-1:0] rline;

  logic in_burst_c;
  logic beat_xfer_c;
  logic accept_wr_c;

  assign in_burst_c  = (state_q == READ) || (state_q == WRITE);
  assign beat_xfer_c = in_burst_c && bus.pmem_resp;
  assign accept_wr_c = (state_q == IDLE) && bus.upstream_write;

  line_beat_shifter #(
    .S_LINE (S_LINE),
    .S_BEAT (S_BEAT)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == DONE),
    .advance_i    (beat_xfer_c),
    .load_wline_i (accept_wr_c),
    .store_beat_i (beat_xfer_c && (state_q == READ)),
    .wline_i      (bus.upstream_wdata),
    .beat_i       (bus.pmem_rdata),
    .last_beat_o  (last_beat),
    .wbeat_o      (wbeat),
    .rline_o      (rline)
  );

  assign bus.pmem_read      = rd_q;
  assign bus.pmem_write     = wr_q;
  assign bus.pmem_address   = addr_q;
  assign bus.pmem_wdata     = wbeat;
  assign bus.upstream_rdata = rline;
  assign bus.upstream_resp  = resp_q;

  // Burst FSM; request strobes drop on the edge that takes the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      resp_q     <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.upstream_write) begin
            state_q    <= WRITE;
            wr_q       <= 1'b1;
            is_write_q <= 1'b1;
            addr_q     <= bus.upstream_address & ADDR_MASK;
          end else if (bus.upstream_read) begin
            state_q    <= READ;
            rd_q       <= 1'b1;
            is_write_q <= 1'b0;
            addr_q     <= bus.upstream_address & ADDR_MASK;
          end
        end
        READ: begin
          if (bus.pmem_resp && last_beat) begin
            state_q <= DONE;
            rd_q    <= 1'b0;
            resp_q  <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.pmem_resp && last_beat) begin
            state_q <= DONE;
            wr_q    <= 1'b0;
            resp_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef LINE_BURST_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_reads        <= '0;
      perf_writes       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state_q == DONE) begin
        if (is_write_q) begin
          perf_writes <= perf_writes + 32'd1;
        end else begin
          perf_reads <= perf_reads + 32'd1;
        end
      end
      if (in_burst_c && !bus.pmem_resp) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Simultaneous read and write is an upstream protocol error; write is taken.
  always @(posedge clk) begin
    if (!rst && (state_q == IDLE)) begin
      assert (!(bus.upstream_read && bus.upstream_write))
        else $warning("line_burst_adapter: read and write requested together, write taken");
    end
  end
`endif

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: reads, writebacks, beat gaps,
// mid-burst reset, read/write collision and the optional perf counters.
module tb_line_burst_adapter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef LINE_BURST_PERF_EN
  logic [31:0] perf_reads;
  logic [31:0] perf_writes;
  logic [31:0] perf_stall_cycles;
`endif

  line_burst_adapter_if #(.S_LINE(256), .S_BEAT(64)) bus ();

  line_burst_adapter dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus)
`ifdef LINE_BURST_PERF_EN
    ,
    .perf_reads        (perf_reads),
    .perf_writes       (perf_writes),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; pat bit c is pmem_resp on the c-th cycle after the request is accepted.
  task automatic burst(input bit wr, input bit both, input logic [31:0] addr,
                       input logic [31:0] exp_addr, input logic [255:0] line,
                       input logic [31:0] pat, input int pat_len);
    int beat;
    beat = 0;
    bus.upstream_write   = wr;
    bus.upstream_read    = !wr || both;
    bus.upstream_address = addr;
    bus.upstream_wdata   = wr ? line : ~line;
    tick();
    for (int c = 0; c < pat_len && beat < 4; c++) begin
      check("burst_req",  256'(wr ? bus.pmem_write : bus.pmem_read), 256'(1));
      check("burst_other", 256'(wr ? bus.pmem_read : bus.pmem_write), 256'(0));
      check("burst_addr", 256'(bus.pmem_address), 256'(exp_addr));
      check("burst_early_resp", 256'(bus.upstream_resp), 256'(0));
      if (wr) check("wr_beat", 256'(bus.pmem_wdata), 256'(line[beat*64 +: 64]));
      if (pat[c]) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line[beat*64 +: 64];
        beat++;
      end else begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = {$urandom, $urandom};
      end
      tick();
    end
    bus.pmem_resp = 1'b0;
    check("beats_taken", 256'(beat), 256'(4));
    check("done_resp", 256'(bus.upstream_resp), 256'(1));
    check("done_req_low", 256'(wr ? bus.pmem_write : bus.pmem_read), 256'(0));
    if (!wr) check("rd_line", bus.upstream_rdata, line);
    bus.upstream_read  = 1'b0;
    bus.upstream_write = 1'b0;
    tick();
    check("resp_one_cycle", 256'(bus.upstream_resp), 256'(0));
    check("idle_no_req", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
  endtask

  logic [255:0] l_rd1, l_wr, l_rst, l_rd0, l_gap, l_both;

  initial begin
    checks = 0;
    errors = 0;
    l_rd1  = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    l_wr   = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    l_rst  = {64'h0123456789ABCDEF, 64'h1020304050607080, 64'h9988776655443322, 64'hCAFEBABEDEADBEEF};
    l_rd0  = {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 64'hC3C3C3C3C3C3C3C3, 64'h3C3C3C3C3C3C3C3C};
    l_gap  = {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555};
    l_both = {64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 64'h123456789ABCDEF0};

    rst = 1'b1;
    bus.upstream_read    = 1'b0;
    bus.upstream_write   = 1'b0;
    bus.upstream_address = '0;
    bus.upstream_wdata   = '0;
    bus.pmem_rdata       = '0;
    bus.pmem_resp        = 1'b0;
    #12;
    check("rst_pmem_read",  256'(bus.pmem_read), 256'(0));
    check("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
    check("rst_resp",       256'(bus.upstream_resp), 256'(0));
    check("rst_addr",       256'(bus.pmem_address), 256'(0));
    check("rst_rdata",      bus.upstream_rdata, 256'(0));
    check("rst_wdata",      256'(bus.pmem_wdata), 256'(0));
    tick();
    rst = 1'b0;
    tick();

    // Stray memory responses while idle must be ignored.
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 64'hBAD0BAD0BAD0BAD0;
    tick();
    tick();
    bus.pmem_resp = 1'b0;
    check("idle_resp_rdata", bus.upstream_rdata, 256'(0));
    check("idle_resp_req",   256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    check("idle_resp_up",    256'(bus.upstream_resp), 256'(0));

    // Writeback interrupted by reset after two beats.
    bus.upstream_write   = 1'b1;
    bus.upstream_address = 32'h0000_1240;
    bus.upstream_wdata   = l_rst;
    tick();
    check("rw_req", 256'(bus.pmem_write), 256'(1));
    bus.pmem_resp = 1'b1;
    tick();
    tick();
    bus.pmem_resp = 1'b0;
    check("rw_beat2", 256'(bus.pmem_wdata), 256'(64'h1020304050607080));
    check("rw_still_req", 256'(bus.pmem_write), 256'(1));
    #2 rst = 1'b1;
    #1;
    check("rw_drop_now", 256'(bus.pmem_write), 256'(0));
    check("rw_no_resp",  256'(bus.upstream_resp), 256'(0));
    check("rw_addr_clr", 256'(bus.pmem_address), 256'(0));
    bus.upstream_write = 1'b0;
    tick();
    check("rw_no_resp2", 256'(bus.upstream_resp), 256'(0));
    rst = 1'b0;
    tick();

    burst(1'b0, 1'b0, 32'h0000_2040, 32'h0000_2040, l_rd0, 32'hF, 4);
    burst(1'b0, 1'b0, 32'h0000_0D9C, 32'h0000_0D80, l_rd1, 32'hF, 4);
    burst(1'b1, 1'b0, 32'h0000_0D80, 32'h0000_0D80, l_wr,  32'hF, 4);
    check("wr_keeps_rdata", bus.upstream_rdata, l_rd1);
    // Beats on cycles 1,4,5,9 of the burst: five gap cycles.
    burst(1'b0, 1'b0, 32'h0000_447F, 32'h0000_4460, l_gap, 32'b1_0001_1001, 9);
    burst(1'b1, 1'b1, 32'h0000_3F00, 32'h0000_3F00, l_both, 32'hF, 4);
    check("both_keeps_rdata", bus.upstream_rdata, l_gap);

`ifdef LINE_BURST_PERF_EN
    check("perf_reads",  256'(perf_reads), 256'(3));
    check("perf_writes", 256'(perf_writes), 256'(2));
    check("perf_stalls", 256'(perf_stall_cycles), 256'(5));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
Name: line_burst_adapter

Overview:
- Sits directly downstream of the L2 cache core's line-wide memory port and drives the physical-memory burst bus.
- Converts one s_line-bit line read or writeback into num_beats sequential s_beat-bit beats.
- Returns one single-cycle line response upstream.
- Holds exactly one transaction at a time and latches address and write data so the cache may change them after acceptance.

Parameters:
- s_offset, 5, line offset bits; line address alignment.
- s_line, 256, line width in bits; must equal 8*2**s_offset.
- s_beat, 64, memory beat width in bits; s_line must be an integer multiple of it.
- num_beats, s_line/s_beat, derived beat count per burst (4 by default).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- upstream_read  in  1  line read request; held until upstream_resp.
- upstream_write  in  1  line writeback request; held until upstream_resp.
- upstream_address  in  32  line address; low s_offset bits ignored.
- upstream_wdata  in  s_line  writeback line.
- upstream_rdata  out  s_line  assembled read line.
- upstream_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  32  line-aligned burst address.
- pmem_wdata  out  s_beat  current write beat.
- pmem_rdata  in  s_beat  current read beat.
- pmem_resp  in  1  beat transferred this cycle.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE; beat counter=0; upstream_resp, pmem_read, pmem_write = 0; pmem_address, upstream_rdata and the internal wdata latch = 0.
- States:
  - IDLE: on upstream_write, latch {address[31:s_offset], 0} and wdata, go to WRITE. Otherwise, on upstream_read, latch address and go to READ. If both are high, write wins and a simulation-only assertion fires.
  - READ: pmem_read=1. Each cycle pmem_resp=1 stores pmem_rdata into the line slice [beat*s_beat +: s_beat] and increments beat. On the final beat, go to DONE.
  - WRITE: pmem_write=1. pmem_wdata = latched line slice for the current beat. Each cycle pmem_resp=1 advances beat. On the final beat, go to DONE.
  - DONE: upstream_resp=1 for exactly one cycle; beat cleared; return to IDLE.
- Beat 0 is bits [s_beat-1:0]; beats proceed in ascending order with no wrap or critical-word-first.
- pmem_resp may deassert between beats: the request stays asserted and the counter holds.
- pmem_read/pmem_write are registered outputs and remain high through the final-beat cycle, dropping in DONE.
- pmem_address is constant for the whole burst.
- Latency: the first pmem request appears 1 cycle after the upstream request. upstream_resp appears 1 cycle after the final beat. Minimum round trip is num_beats+2 cycles.
- upstream_rdata is stable from the upstream_resp cycle until the next read's first beat. Write transactions do not modify it.
- Requests seen in DONE are ignored; the cache deasserts on resp. A request still high in IDLE after DONE is treated as new, which is a protocol violation by the upstream.
- pmem_resp received in IDLE or DONE is ignored.
- Counter width is clog2(num_beats) bits, with no overflow past num_beats-1.
- Reset asserted mid-burst abandons the burst and drops pmem requests the same instant.

Optional Feature:
- Macro: LINE_BURST_PERF_EN.
- With the macro defined:
  - Adds outputs perf_reads[31:0], perf_writes[31:0] and perf_stall_cycles[31:0], all reset to 0.
  - perf_reads and perf_writes increment in DONE according to the transaction type.
  - perf_stall_cycles increments on every READ/WRITE cycle with pmem_resp=0.
  - All counters wrap at 2^32.
- Without the macro: these ports and registers are absent and the remaining behaviour is identical.

Decomposition:
- Shared package cache_types_pkg:
  - adapter state enum {IDLE, READ, WRITE, DONE}.
  - Default widths S_LINE=256, S_BEAT=64.
  - NUM_BEATS constant.
- One natural sub-module, line_beat_shifter: holds the line register plus beat counter and provides slice-select/slice-load. The FSM stays in the top module.

Test Plan:
- Read, address 0x0000_0D9C: memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> pmem_address=0x0000_0D80; upstream_rdata=0x44..44_33..33_22..22_11..11; upstream_resp pulses 1 cycle, 6 cycles after request.
- Writeback, address 0xD80, wdata=0xDDDD..._CCCC..._BBBB..._AAAA...: pmem_resp held high -> pmem_wdata presents AAAA, BBBB, CCCC, DDDD in order; single resp pulse.
- Read with pmem_resp gaps (beats on cycles 1,4,5,9) -> counter holds during gaps; correct line assembled; pmem_read stays high until the final beat.
- rst asserted after beat 2 of a write -> pmem_write drops immediately; no upstream_resp. A following read completes normally with beat 0 re-fetched.
- upstream_read and upstream_write both high in IDLE -> write burst issued; assertion reported.
- With LINE_BURST_PERF_EN: 3 reads, 2 writes, 5 gap cycles -> perf_reads=3, perf_writes=2, perf_stall_cycles=5.
